ifmap_data_feeder: RTL and testbench
====================================

// Module: ifmap_data_feeder
// PURPOSE
// - Responder side of the engine's input-data request/valid port: buffers channel-packed ifmap words from the DMA/loader.
// - Returns one word per granted core request (o_data_req -> i_data/i_data_val on the core side).
// - Sits between the input stream loader and accelerator_core; counts words per layer and flags completion.
// PARAMETERS
// - BIT_WIDTH    8   bits per channel element
// - NUM_CHANNEL  3   channels packed per word; word width DW = BIT_WIDTH*NUM_CHANNEL
// - FIFO_DEPTH   16  buffer entries; power of two, >= 2
// - REG_WIDTH    32  config register width
// PORTS
// - clk          in   1          single clock, rising edge
// - rst          in   1          synchronous reset, active-high
// - i_wr_data    in   DW         word from loader
// - i_wr_val     in   1          loader word valid
// - o_wr_rdy     out  1          feeder can accept word (= !full)
// - i_data_req   in   1          core request, level, one word per high cycle
// - o_data       out  DW         word to core
// - o_data_val   out  1          o_data valid, single-cycle pulse per word
// - i_conf_ctrl  in   REG_WIDTH  bit0 = enable, bit1 = flush, others ignored
// - i_conf_cnt   in   REG_WIDTH  words to deliver this layer
// - o_level      out  log2(FIFO_DEPTH)+1  current FIFO occupancy
// - o_done       out  1          layer delivered, high in DONE state
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE. o_data=0, o_data_val=0, o_wr_rdy=1, o_level=0, o_done=0, counters=0.
// - FIFO: write when i_wr_val&&o_wr_rdy, in any state except during flush.
//   - o_wr_rdy is derived from the registered full flag, so a write is refused when full even if a pop happens in the same cycle.
//   - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit. full = addresses equal and wrap bits differ.
// - FSM, three states:
//   - IDLE -> RUN when ctrl[0]=1 and i_conf_cnt!=0. On entry, latch total=i_conf_cnt and clear sent_cnt.
//   - RUN -> DONE on the pop where sent_cnt==total-1.
//   - DONE -> IDLE when ctrl[0]=0.
//   - i_conf_cnt changes after entering RUN are ignored.
// - Pop (grant) = state==RUN && i_data_req && !empty.
//   - Next cycle: o_data = popped word and o_data_val = 1. Latency is exactly 1 cycle from granted req.
//   - On cycles without a pop, o_data_val = 0 and o_data holds its last value.
// - No bypass: a write into an empty FIFO and a req in the same cycle give no pop. The pop occurs on the next cycle if req is still high.
// - Simultaneous write and pop when neither full nor empty: occupancy is unchanged.
// - Req while empty, or in IDLE/DONE: no pop, no error. The request is simply not granted. Req is never queued.
// - Leftover FIFO words in DONE are retained for the next layer.
// - Flush (ctrl[1]=1): in that cycle, reset pointers, sent_cnt and state to IDLE; o_data_val=0; incoming write dropped.
//   - Flush has priority over pop, write and FSM transitions.
//   - Holding flush high keeps the block in IDLE with o_wr_rdy=1.
// - Reset or flush mid-layer discards all buffered words and the partial count.
// CONFIGURATION
// - Macro IFMAP_FEEDER_STAT_EN.
// - Defined: adds output o_stall_cnt, REG_WIDTH bits.
//   - Increments each cycle that state==RUN && i_data_req && empty, saturating at all-ones.
//   - Cleared by rst, by flush, and on IDLE->RUN.
// - Undefined: port and counter absent. All other behaviour is identical.
// TESTING
// - Basic: cnt=4, enable, push 0x010203..0x0A0B0C, req held high -> 4 val pulses on consecutive cycles, in order.
//   Each pulse is 1 cycle after its granted req; o_done rises the cycle after the 4th pop.
// - Full/backpressure: req=0, push 17 words with DEPTH=16 -> o_wr_rdy=0 after 16, o_level=16, 17th word held by loader.
//   One pop restores rdy the next cycle.
// - Underflow: enable, req high, FIFO empty for 5 cycles, then push 1 word -> no val during the 5 cycles.
//   val 2 cycles after the write; with STAT_EN, o_stall_cnt=5 plus the write cycle = 6.
// - Simultaneous: level=1, write and req the same cycle -> level stays 1, val next cycle.
//   Empty with write+req same cycle -> pop on the following cycle.
// - Flush mid-layer: cnt=8, 3 words sent, 5 buffered, assert flush 1 cycle -> level=0, IDLE, o_done=0, no val.
//   Re-enable with cnt=2 delivers only newly pushed words.
// - Completion and reuse: after DONE, req high -> no val. Drop enable -> IDLE, o_done=0.
//   Re-enable with cnt=1 -> first retained word delivered.

Source files
------------

// File: rtl/ifmap_data_feeder_if.sv
// Loader/core handshake bundle for the ifmap feeder: loader write port and core request/valid port.
// slave = feeder side, master = loader/core side.
interface ifmap_data_feeder_if #(
  parameter int DW = 24
);
  logic [DW-1:0] i_wr_data;
  logic          i_wr_val;
  logic          o_wr_rdy;
  logic          i_data_req;
  logic [DW-1:0] o_data;
  logic          o_data_val;

  modport slave (
    input  i_wr_data, i_wr_val, i_data_req,
    output o_wr_rdy, o_data, o_data_val
  );

  modport master (
    output i_wr_data, i_wr_val, i_data_req,
    input  o_wr_rdy, o_data, o_data_val
  );
endinterface

// File: rtl/ifmap_data_feeder.sv
// Buffers channel-packed ifmap words and hands one per granted core request, counting words per layer.
// Optional IFMAP_FEEDER_STAT_EN adds o_stall_cnt (cycles spent requesting from an empty buffer in RUN).
module ifmap_data_feeder #(
  parameter  int BIT_WIDTH   = 8,
  parameter  int NUM_CHANNEL = 3,
  parameter  int FIFO_DEPTH  = 16,
  parameter  int REG_WIDTH   = 32,
  localparam int DW          = BIT_WIDTH * NUM_CHANNEL,
  localparam int AW          = $clog2(FIFO_DEPTH),
  localparam int LW          = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ifmap_data_feeder_if.slave   bus,
  input  logic [REG_WIDTH-1:0] i_conf_ctrl,
  input  logic [REG_WIDTH-1:0] i_conf_cnt,
  output logic [LW-1:0]        o_level,
  output logic                 o_done
`ifdef IFMAP_FEEDER_STAT_EN
  ,
  output logic [REG_WIDTH-1:0] o_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [REG_WIDTH-1:0] total, sent_cnt;
  logic                 full, empty, push, pop, start, last_pop;
  logic                 en, flush;
  logic                 unused_ctrl;

  assign en          = i_conf_ctrl[0];
  assign flush       = i_conf_ctrl[1];
  assign unused_ctrl = ^i_conf_ctrl[REG_WIDTH-1:2];

  // Wrap bit distinguishes full from empty when addresses coincide.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  assign bus.o_wr_rdy = !full;
  assign o_level      = wr_ptr - rd_ptr;
  assign o_done       = (state_q == DONE);

  // Both qualifiers use registered pointers only, so there is no write-to-read bypass.
  assign push     = bus.i_wr_val && !full && !flush;
  assign pop      = (state_q == RUN) && bus.i_data_req && !empty && !flush;
  assign last_pop = (sent_cnt == total - REG_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (en && (i_conf_cnt != '0)) begin
          state_d = RUN;
          start   = 1'b1;
        end
        RUN:  if (pop && last_pop) state_d = DONE;
        DONE: if (!en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      total          <= '0;
      sent_cnt       <= '0;
      bus.o_data     <= '0;
      bus.o_data_val <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus.o_data_val <= pop;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        sent_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr     <= rd_ptr + 1'b1;
          bus.o_data <= mem[rd_ptr[AW-1:0]];
        end
        if (start) begin
          total    <= i_conf_cnt;
          sent_cnt <= '0;
        end else if (pop) begin
          sent_cnt <= sent_cnt + 1'b1;
        end
      end
    end
  end

`ifdef IFMAP_FEEDER_STAT_EN
  always_ff @(posedge clk) begin
    if (rst || flush || start)
      o_stall_cnt <= '0;
    else if ((state_q == RUN) && bus.i_data_req && empty && (o_stall_cnt != '1))
      o_stall_cnt <= o_stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ifmap_data_feeder.sv
// Directed bench for ifmap_data_feeder: reset, streaming, backpressure, underflow, flush and layer reuse.
module tb_ifmap_data_feeder;
  localparam int DW = 24;
  localparam int RW = 32;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] ctrl, cnt;
  logic [LW-1:0] level;
  logic          done;
`ifdef IFMAP_FEEDER_STAT_EN
  logic [RW-1:0] stall;
`endif
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifmap_data_feeder_if #(.DW(DW)) bus ();

  ifmap_data_feeder #(
    .BIT_WIDTH(8), .NUM_CHANNEL(3), .FIFO_DEPTH(16), .REG_WIDTH(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .i_conf_ctrl(ctrl),
    .i_conf_cnt(cnt),
    .o_level(level),
    .o_done(done)
`ifdef IFMAP_FEEDER_STAT_EN
    ,
    .o_stall_cnt(stall)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    bus.i_wr_data = w;
    bus.i_wr_val  = 1'b1;
    tick();
    bus.i_wr_val  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ctrl = '0; cnt = '0;
    bus.i_wr_data = '0; bus.i_wr_val = 1'b0; bus.i_data_req = 1'b0;
    tick(); tick();
    checks++; if (bus.o_data !== 24'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.o_data); end
    checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL reset_val got=%0b exp=0", bus.o_data_val); end
    checks++; if (bus.o_wr_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%0b exp=1", bus.o_wr_rdy); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
`ifdef IFMAP_FEEDER_STAT_EN
    checks++; if (stall !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [DW-1:0] w [4];
    w[0] = 24'h010203; w[1] = 24'h040506; w[2] = 24'h070809; w[3] = 24'h0A0B0C;
    for (int i = 0; i < 4; i++) push(w[i]);
    checks++; if (level !== 5'd4) begin failures++; $display("FAIL basic_level got=%0d exp=4", level); end
    ctrl = 32'd1; cnt = 32'd4; bus.i_data_req = 1'b1;
    tick();
    checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL basic_entry_val got=%0b exp=0", bus.o_data_val); end
    cnt = 32'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.o_data_val !== 1'b1) begin failures++; $display("FAIL basic_val[%0d] got=%0b exp=1", i, bus.o_data_val); end
      checks++; if (bus.o_data !== w[i]) begin failures++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, bus.o_data, w[i]); end
      checks++; if (done !== (i == 3)) begin failures++; $display("FAIL basic_done[%0d] got=%0b exp=%0b", i, done, (i == 3)); end
    end
    tick();
    checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL basic_after_val got=%0b exp=0", bus.o_data_val); end
    checks++; if (bus.o_data !== w[3]) begin failures++; $display("FAIL basic_hold_data got=%0h exp=%0h", bus.o_data, w[3]); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL basic_after_level got=%0d exp=0", level); end
    bus.i_data_req = 1'b0;
  endtask

  task automatic test_full;
    ctrl = 32'd0;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_idle_done got=%0b exp=0", done); end
    for (int i = 0; i < 16; i++) push(24'h100000 + DW'(i));
    checks++; if (bus.o_wr_rdy !== 1'b0) begin failures++; $display("FAIL full_rdy got=%0b exp=0", bus.o_wr_rdy); end
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", level); end
    bus.i_wr_data = 24'h100010; bus.i_wr_val = 1'b1;
    tick();
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_refuse_level got=%0d exp=16", level); end
    ctrl = 32'd1; cnt = 32'd1; bus.i_data_req = 1'b1;
    tick();
    checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL full_entry_val got=%0b exp=0", bus.o_data_val); end
    tick();
    checks++; if (bus.o_data_val !== 1'b1) begin failures++; $display("FAIL full_pop_val got=%0b exp=1", bus.o_data_val); end
    checks++; if (bus.o_data !== 24'h100000) begin failures++; $display("FAIL full_pop_data got=%0h exp=100000", bus.o_data); end
    checks++; if (level !== 5'd15) begin failures++; $display("FAIL full_pop_level got=%0d exp=15", level); end
    checks++; if (bus.o_wr_rdy !== 1'b1) begin failures++; $display("FAIL full_pop_rdy got=%0b exp=1", bus.o_wr_rdy); end
    bus.i_data_req = 1'b0;
    tick();
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_17th_level got=%0d exp=16", level); end
    checks++; if (bus.o_wr_rdy !== 1'b0) begin failures++; $display("FAIL full_17th_rdy got=%0b exp=0", bus.o_wr_rdy); end
    bus.i_wr_val = 1'b0;
    ctrl = 32'd2;
    tick();
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL full_flush_level got=%0d exp=0", level); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_flush_done got=%0b exp=0", done); end
    bus.i_wr_data = 24'h777777; bus.i_wr_val = 1'b1;
    tick();
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL flush_hold_level got=%0d exp=0", level); end
    checks++; if (bus.o_wr_rdy !== 1'b1) begin failures++; $display("FAIL flush_hold_rdy got=%0b exp=1", bus.o_wr_rdy); end
    bus.i_wr_val = 1'b0; ctrl = 32'd0;
  endtask

  task automatic test_underflow;
    ctrl = 32'd1; cnt = 32'd1; bus.i_data_req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL under_val[%0d] got=%0b exp=0", i, bus.o_data_val); end
    end
    bus.i_wr_data = 24'hABCDEF; bus.i_wr_val = 1'b1;
    tick();
    bus.i_wr_val = 1'b0;
    checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL under_wr_val got=%0b exp=0", bus.o_data_val); end
    tick();
    checks++; if (bus.o_data_val !== 1'b1) begin failures++; $display("FAIL under_pop_val got=%0b exp=1", bus.o_data_val); end
    checks++; if (bus.o_data !== 24'hABCDEF) begin failures++; $display("FAIL under_pop_data got=%0h exp=abcdef", bus.o_data); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL under_done got=%0b exp=1", done); end
`ifdef IFMAP_FEEDER_STAT_EN
    checks++; if (stall !== 32'd6) begin failures++; $display("FAIL under_stall got=%0d exp=6", stall); end
`endif
    bus.i_data_req = 1'b0;
  endtask

  task automatic test_simultaneous;
    ctrl = 32'd0;
    tick();
    push(24'h111111);
    ctrl = 32'd1; cnt = 32'd3;
    tick();
    bus.i_wr_data = 24'h222222; bus.i_wr_val = 1'b1; bus.i_data_req = 1'b1;
    tick();
    bus.i_wr_val = 1'b0;
    checks++; if (level !== 5'd1) begin failures++; $display("FAIL simul_level got=%0d exp=1", level); end
    checks++; if (bus.o_data !== 24'h111111) begin failures++; $display("FAIL simul_data got=%0h exp=111111", bus.o_data); end
    tick();
    checks++; if (bus.o_data !== 24'h222222) begin failures++; $display("FAIL simul_data2 got=%0h exp=222222", bus.o_data); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL simul_empty_level got=%0d exp=0", level); end
    bus.i_wr_data = 24'h333333; bus.i_wr_val = 1'b1;
    tick();
    bus.i_wr_val = 1'b0;
    checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL nobypass_val got=%0b exp=0", bus.o_data_val); end
    checks++; if (level !== 5'd1) begin failures++; $display("FAIL nobypass_level got=%0d exp=1", level); end
    tick();
    checks++; if (bus.o_data_val !== 1'b1) begin failures++; $display("FAIL nobypass_pop_val got=%0b exp=1", bus.o_data_val); end
    checks++; if (bus.o_data !== 24'h333333) begin failures++; $display("FAIL nobypass_pop_data got=%0h exp=333333", bus.o_data); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL simul_done got=%0b exp=1", done); end
    bus.i_data_req = 1'b0;
  endtask

  task automatic test_flush;
    ctrl = 32'd0;
    tick();
    for (int i = 0; i < 8; i++) push(24'h200000 + DW'(i));
    ctrl = 32'd1; cnt = 32'd8; bus.i_data_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.o_data !== 24'h200002) begin failures++; $display("FAIL flush_pre_data got=%0h exp=200002", bus.o_data); end
    checks++; if (level !== 5'd5) begin failures++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
    ctrl = 32'd3; bus.i_wr_data = 24'hEEEEEE; bus.i_wr_val = 1'b1;
    tick();
    checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL flush_val got=%0b exp=0", bus.o_data_val); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_done got=%0b exp=0", done); end
    bus.i_wr_val = 1'b0; ctrl = 32'd0; bus.i_data_req = 1'b0;
    push(24'h444444);
    push(24'h555555);
    ctrl = 32'd1; cnt = 32'd2; bus.i_data_req = 1'b1;
    tick();
    tick();
    checks++; if (bus.o_data !== 24'h444444) begin failures++; $display("FAIL reflush_data0 got=%0h exp=444444", bus.o_data); end
    tick();
    checks++; if (bus.o_data !== 24'h555555) begin failures++; $display("FAIL reflush_data1 got=%0h exp=555555", bus.o_data); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL reflush_done got=%0b exp=1", done); end
  endtask

  task automatic test_reuse;
    push(24'h666666);
    push(24'h888888);
    tick();
    checks++; if (bus.o_data_val !== 1'b0) begin failures++; $display("FAIL reuse_done_val got=%0b exp=0", bus.o_data_val); end
    checks++; if (level !== 5'd2) begin failures++; $display("FAIL reuse_level got=%0d exp=2", level); end
    ctrl = 32'd0;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reuse_idle_done got=%0b exp=0", done); end
    ctrl = 32'd1; cnt = 32'd1;
    tick();
    tick();
    checks++; if (bus.o_data_val !== 1'b1) begin failures++; $display("FAIL reuse_val got=%0b exp=1", bus.o_data_val); end
    checks++; if (bus.o_data !== 24'h666666) begin failures++; $display("FAIL reuse_data got=%0h exp=666666", bus.o_data); end
    checks++; if (level !== 5'd1) begin failures++; $display("FAIL reuse_left_level got=%0d exp=1", level); end
    bus.i_data_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", level); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_simultaneous();
    test_flush();
    test_reuse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
